// File: rtl/reg_wb_buffer_pkg.sv
// Shared register-file geometry used by the write-back buffer and its forwarding logic.
package reg_wb_buffer_pkg;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_ADDR_NUM   = 32;
  localparam int unsigned WB_DEPTH      = 4;
endpackage

// File: rtl/reg_wb_buffer_fwd_match.sv
// Newest-match lookup over the write-back queue: returns the data of the youngest valid
// entry whose destination equals raddr (x0 never hits).
module reg_wb_fwd_match #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] waddrs,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] wdatas,
  input  logic [DEPTH-1:0]                 valids,
  input  logic [PTR_W-1:0]                 tail,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            data
);

  logic [PTR_W-1:0] idx;

  // Walk from tail (oldest slot position) around to tail-1 (youngest); later matches override.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail + PTR_W'(k);
      if (raddr != '0 && valids[idx] && waddrs[idx] == raddr) begin
        hit  = 1'b1;
        data = wdatas[idx];
      end
    end
  end

endmodule

// File: rtl/reg_wb_buffer.sv
// Write-back request queue in front of the register-file write port, with two-port
// newest-match forwarding so decode observes pending writes.
module reg_wb_buffer
  import reg_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = WB_DEPTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  drain_en,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  fwd_hit1,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data2,
  output logic                  empty
);

  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;
  logic [DEPTH-1:0]                 ent_valid;
  logic [PTR_W-1:0]                 head;
  logic [PTR_W-1:0]                 tail;
  logic [PTR_W:0]                   count;
  logic                             accept;
  logic                             store;

  assign empty    = (count == '0);
  assign in_ready = !rst && (count != FULL_CNT);
  assign accept   = in_valid && in_ready;
  // x0 writes complete the handshake but never occupy a slot.
  assign store    = accept && (in_waddr != '0);
  assign rf_wen   = !empty && drain_en && !rst;
  assign rf_waddr = empty ? '0 : ent_addr[head];
  assign rf_wdata = empty ? '0 : ent_data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (store) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (rf_wen) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({store, rf_wen})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      ent_addr[tail] <= in_waddr;
      ent_data[tail] <= in_wdata;
    end
  end

  reg_wb_fwd_match #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fwd1 (
    .waddrs(ent_addr), .wdatas(ent_data), .valids(ent_valid), .tail(tail),
    .raddr(raddr1), .hit(fwd_hit1), .data(fwd_data1)
  );

  reg_wb_fwd_match #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fwd2 (
    .waddrs(ent_addr), .wdatas(ent_data), .valids(ent_valid), .tail(tail),
    .raddr(raddr2), .hit(fwd_hit2), .data(fwd_data2)
  );

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Bench for reg_wb_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_reg_wb_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        drain_en;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic        empty;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic last_held = 1'b0;

  always #5 clk = ~clk;

  reg_wb_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_waddr(in_waddr), .in_wdata(in_wdata), .drain_en(drain_en),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2), .empty(empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_fwd(input logic [4:0] ra, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (ra != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == ra) begin
          hit  = 1'b1;
          data = q[i].d;
          break;
        end
      end
    end
  endfunction

  task automatic set_in(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic dr, input logic [4:0] r1, input logic [4:0] r2);
    rst = 1'b0; in_valid = v; in_waddr = a; in_wdata = d;
    drain_en = dr; raddr1 = r1; raddr2 = r2;
    #1;
  endtask

  // Compare all outputs against the model at the falling edge, then advance the model.
  task automatic tick();
    logic e_ready, e_wen, e_h1, e_h2, acc;
    logic [31:0] e_d1, e_d2;
    @(negedge clk);
    e_ready = !rst && (q.size() != DEPTH);
    e_wen   = !rst && drain_en && (q.size() != 0);
    model_fwd(raddr1, e_h1, e_d1);
    model_fwd(raddr2, e_h2, e_d2);
    check("in_ready", in_ready, e_ready);
    check("empty", empty, q.size() == 0);
    check("rf_wen", rf_wen, e_wen);
    check("rf_waddr", rf_waddr, q.size() != 0 ? q[0].a : 5'd0);
    check("rf_wdata", rf_wdata, q.size() != 0 ? q[0].d : 32'd0);
    check("fwd_hit1", fwd_hit1, e_h1);
    check("fwd_data1", fwd_data1, e_d1);
    check("fwd_hit2", fwd_hit2, e_h2);
    check("fwd_data2", fwd_data2, e_d2);
    acc = in_valid && e_ready;
    last_held = in_valid && !acc && !rst;
    if (rst) q.delete();
    else begin
      if (e_wen) void'(q.pop_front());
      if (acc && in_waddr != 0) q.push_back('{a: in_waddr, d: in_wdata});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  seq_a[$];
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [4:0]  w_a[4];
    logic [31:0] w_d[4];

    rst = 1'b1; in_valid = 0; in_waddr = 0; in_wdata = 0;
    drain_en = 0; raddr1 = 0; raddr2 = 0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state
    set_in(0, 0, 0, 0, 5, 9);
    check("rst_empty", empty, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_hit1", fwd_hit1, 0);
    check("rst_hit2", fwd_hit2, 0);
    tick();

    // 2: single request, one-cycle latency to the write port
    set_in(1, 5, 32'hDEADBEEF, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    check("lat_wen", rf_wen, 1);
    check("lat_waddr", rf_waddr, 5);
    check("lat_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    check("lat_empty", empty, 1);

    // 3: fill with drain blocked, forwarding picks the youngest, then ordered drain
    w_a = '{5'd3, 5'd3, 5'd7, 5'd3};
    w_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      set_in(1, w_a[i], w_d[i], 0, 3, 7);
      tick();
    end
    set_in(1, 5'd9, 32'h99, 0, 3, 7);
    check("full_ready", in_ready, 0);
    check("full_hit1", fwd_hit1, 1);
    check("full_data1", fwd_data1, 32'h44);
    check("full_hit2", fwd_hit2, 1);
    check("full_data2", fwd_data2, 32'h33);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, 3, 7);
      check("order_waddr", rf_waddr, w_a[i]);
      check("order_wdata", rf_wdata, w_d[i]);
      tick();
    end

    // 4: x0 write is accepted and dropped
    set_in(1, 0, 32'h55, 1, 0, 0);
    check("x0_ready", in_ready, 1);
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    check("x0_empty", empty, 1);
    check("x0_wen", rf_wen, 0);
    check("x0_hit1", fwd_hit1, 0);
    tick();

    // 5: steady accept+drain at count 2 with pointer wrap
    for (int i = 0; i < 2; i++) begin
      set_in(1, 5'(8 + i), 32'(32'h100 + i), 0, 0, 0);
      seq_a.push_back(5'(8 + i));
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1, 5'(10 + i), 32'(32'h200 + i), 1, 5'(10 + i), 5'(8 + i));
      seq_a.push_back(5'(10 + i));
      check("wrap_wen", rf_wen, 1);
      check("wrap_waddr", rf_waddr, seq_a[i]);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    check("wrap_not_empty", empty, 0);
    repeat (2) begin set_in(0, 0, 0, 1, 0, 0); tick(); end

    // 6: reset discards pending writes
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(20 + i), 32'(32'h300 + i), 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 1, 20, 21);
    rst = 1'b1;
    #1;
    check("rst_mid_wen", rf_wen, 0);
    check("rst_mid_ready", in_ready, 0);
    tick();
    set_in(0, 0, 0, 1, 20, 21);
    check("post_rst_empty", empty, 1);
    check("post_rst_wen", rf_wen, 0);
    check("post_rst_hit1", fwd_hit1, 0);
    tick();

    // Random traffic; a stalled request is held unchanged until accepted.
    for (int c = 0; c < 400; c++) begin
      if (last_held) begin
        ra = in_waddr; rd = in_wdata;
        set_in(1, ra, rd, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)));
      end else begin
        set_in(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        #1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
